// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a 2-entry skid buffer.
// The EX-side bundle is decoded (store byte enables, lane-replicated store
// data, misalignment) before it is registered. The main entry drives mem_*.
// The skid entry holds one overflow bundle while MEM stalls.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of every held entry and the current input
//   ex_valid/ex_ready   EX-side handshake (ex_ready is registered, = !skid full)
//   ex_*                ALU result, store source, rd and control from EX
//   mem_valid/mem_ready MEM-side handshake
//   mem_*               registered, decoded bundle toward MEM
module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [WIDTH-1:0] ex_alu_result,
  input  logic [WIDTH-1:0] ex_rs2_data,
  input  logic [RD_W-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_funct3,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] mem_alu_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [3:0]       mem_byte_en,
  output logic [RD_W-1:0]  mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [2:0]       mem_funct3,
  output logic             mem_misaligned
);

  typedef struct packed {
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] store_data;
    logic [3:0]       byte_en;
    logic [RD_W-1:0]  rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [2:0]       funct3;
    logic             misaligned;
  } bundle_t;

  // Decode one EX bundle into the form held by both entries.
  function automatic bundle_t decode(
    input logic [WIDTH-1:0] alu,
    input logic [WIDTH-1:0] rs2,
    input logic [RD_W-1:0]  rd,
    input logic             reg_write,
    input logic             mem_read,
    input logic             mem_write,
    input logic [2:0]       funct3
  );
    bundle_t    b;
    logic [1:0] a;
    logic [3:0] be;
    logic       mis_raw;
    logic       mis;
    a = alu[1:0];
    b.store_data = rs2;
    case (funct3)
      3'b000, 3'b100: begin
        be           = 4'b0001 << a;
        b.store_data = {(WIDTH/8){rs2[7:0]}};
        mis_raw      = 1'b0;
      end
      3'b001, 3'b101: begin
        be           = 4'b0011 << a;
        b.store_data = {(WIDTH/16){rs2[15:0]}};
        mis_raw      = a[0];
      end
      3'b010: begin
        be      = 4'b1111;
        mis_raw = (a != 2'b00);
      end
      default: begin
        be      = 4'b0000;
        mis_raw = 1'b0;
      end
    endcase
    // Misalignment only matters for real memory accesses; it suppresses them.
    mis          = mis_raw && (mem_read || mem_write);
    b.alu_result = alu;
    b.rd         = rd;
    b.reg_write  = reg_write;
    b.mem_read   = mem_read && !mis;
    b.mem_write  = mem_write && !mis;
    b.byte_en    = (mem_write && !mis) ? be : 4'b0000;
    b.funct3     = funct3;
    b.misaligned = mis;
    return b;
  endfunction

  bundle_t main_r;
  bundle_t skid_r;
  bundle_t in_bundle_s;
  logic    main_valid_r;
  logic    skid_valid_r;
  logic    ex_ready_r;
  logic    in_fire_s;
  logic    drain_s;

  // Decode the incoming bundle and derive the handshake events of this cycle.
  always_comb begin
    in_bundle_s = decode(ex_alu_result, ex_rs2_data, ex_rd, ex_reg_write,
                         ex_mem_read, ex_mem_write, ex_funct3);
    in_fire_s   = ex_valid && ex_ready_r;
    drain_s     = !main_valid_r || mem_ready;
  end

  // Main/skid entry update; skid always refills main first to keep FIFO order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ex_ready_r   <= 1'b1;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ex_ready_r   <= 1'b1;
    end else if (drain_s) begin
      if (skid_valid_r) begin
        // ex_ready was low, so no input can arrive alongside this move.
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
        ex_ready_r   <= 1'b1;
      end else if (in_fire_s) begin
        main_r       <= in_bundle_s;
        main_valid_r <= 1'b1;
        ex_ready_r   <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
        ex_ready_r   <= 1'b1;
      end
    end else begin
      if (in_fire_s) begin
        skid_r       <= in_bundle_s;
        skid_valid_r <= 1'b1;
        ex_ready_r   <= 1'b0;
      end else begin
        ex_ready_r   <= !skid_valid_r;
      end
    end
  end

  assign ex_ready       = ex_ready_r;
  assign mem_valid      = main_valid_r;
  assign mem_alu_result = main_r.alu_result;
  assign mem_store_data = main_r.store_data;
  assign mem_byte_en    = main_r.byte_en;
  assign mem_rd         = main_r.rd;
  assign mem_reg_write  = main_r.reg_write;
  assign mem_mem_read   = main_r.mem_read;
  assign mem_mem_write  = main_r.mem_write;
  assign mem_funct3     = main_r.funct3;
  assign mem_misaligned = main_r.misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: self-checking bench for ex_mem_stage. A queue of at most
// two expected bundles models the stage; every cycle the DUT outputs are
// compared to the queue head. Directed cases pin hand-computed literals.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid, ex_ready, mem_valid, mem_ready;
  logic [31:0] ex_alu_result, ex_rs2_data, mem_alu_result, mem_store_data;
  logic [4:0]  ex_rd, mem_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3, mem_funct3;
  logic [3:0]  mem_byte_en;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic        mis;
  } exp_t;

  exp_t q[$];

  ex_mem_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_byte_en(mem_byte_en), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_funct3(mem_funct3), .mem_misaligned(mem_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected decoded bundle for the inputs currently driven, from access size rules.
  function automatic exp_t model_bundle();
    exp_t e;
    int   size;
    int   a;
    a = int'(ex_alu_result[1:0]);
    case (ex_funct3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e.mis = (size > 1) && ((a % size) != 0) && (ex_mem_read || ex_mem_write);
    e.mr  = ex_mem_read && !e.mis;
    e.mw  = ex_mem_write && !e.mis;
    e.be  = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (e.mw && size > 0 && i >= a && i < a + size) e.be[i] = 1'b1;
    e.sd = ex_rs2_data;
    if (size == 1 || size == 2)
      for (int i = 0; i < 4; i++) e.sd[8*i +: 8] = ex_rs2_data[8*(i % size) +: 8];
    e.alu = ex_alu_result;
    e.rd  = ex_rd;
    e.rw  = ex_reg_write;
    e.f3  = ex_funct3;
    return e;
  endfunction

  task automatic model_update();
    logic push;
    logic pop;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      push = ex_valid && (q.size() < 2);
      pop  = (q.size() > 0) && mem_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(model_bundle());
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, q.size() > 0});
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      e = q[0];
      chk("alu_result", mem_alu_result, e.alu);
      chk("store_data", mem_store_data, e.sd);
      chk("byte_en", {28'd0, mem_byte_en}, {28'd0, e.be});
      chk("rd", {27'd0, mem_rd}, {27'd0, e.rd});
      chk("ctl", {26'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_funct3},
          {26'd0, e.rw, e.mr, e.mw, e.f3});
      chk("misaligned", {31'd0, mem_misaligned}, {31'd0, e.mis});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic rd_en, input logic wr_en, input logic [2:0] f3);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_rs2_data   = rs2;
    ex_rd         = 5'd7;
    ex_reg_write  = rd_en;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_funct3     = f3;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    #12;
    chk("reset_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset_ready", {31'd0, ex_ready}, 32'd1);
    chk("reset_alu", mem_alu_result, 32'd0);
    chk("reset_be", {28'd0, mem_byte_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming ADD results with MEM always ready.
    drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 3'b000); ex_reg_write = 1'b1; step();
    chk("stream_0x10", mem_alu_result, 32'h10);
    drive(1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 3'b000); ex_reg_write = 1'b1; step();
    chk("stream_0x20", mem_alu_result, 32'h20);
    drive(1'b1, 32'h30, 32'h0, 1'b0, 1'b0, 3'b000); ex_reg_write = 1'b1; step();
    chk("stream_0x30", mem_alu_result, 32'h30);
    chk("stream_ready", {31'd0, ex_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000); step();

    // Backpressure: A in main, B in skid, then drain in order.
    mem_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h0, 1'b0, 1'b0, 3'b000); step();
    drive(1'b1, 32'h2, 32'h0, 1'b0, 1'b0, 3'b000); step();
    chk("bp_ready_low", {31'd0, ex_ready}, 32'd0);
    chk("bp_head_a", mem_alu_result, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000); step();
    chk("bp_hold_a", mem_alu_result, 32'h1);
    mem_ready = 1'b1; step();
    chk("bp_then_b", mem_alu_result, 32'h2);
    step();
    chk("bp_empty", {31'd0, mem_valid}, 32'd0);

    // Stores.
    drive(1'b1, 32'h103, 32'hAABBCCDD, 1'b0, 1'b1, 3'b000); step();
    chk("sb_be", {28'd0, mem_byte_en}, 32'b1000);
    chk("sb_data", mem_store_data, 32'hDDDDDDDD);
    drive(1'b1, 32'h102, 32'hAABBCCDD, 1'b0, 1'b1, 3'b001); step();
    chk("sh_be", {28'd0, mem_byte_en}, 32'b1100);
    chk("sh_data", mem_store_data, 32'hCCDDCCDD);
    drive(1'b1, 32'h100, 32'hAABBCCDD, 1'b0, 1'b1, 3'b010); step();
    chk("sw_be", {28'd0, mem_byte_en}, 32'b1111);
    chk("sw_data", mem_store_data, 32'hAABBCCDD);

    // Misaligned accesses.
    drive(1'b1, 32'h102, 32'hAABBCCDD, 1'b0, 1'b1, 3'b010); step();
    chk("sw_mis", {31'd0, mem_misaligned}, 32'd1);
    chk("sw_mis_wr", {31'd0, mem_mem_write}, 32'd0);
    chk("sw_mis_be", {28'd0, mem_byte_en}, 32'd0);
    drive(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 3'b001); step();
    chk("lh_mis", {31'd0, mem_misaligned}, 32'd1);
    chk("lh_mis_rd", {31'd0, mem_mem_read}, 32'd0);
    chk("lh_mis_rw", {31'd0, mem_reg_write}, 32'd1);
    drive(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 3'b000); step();
    chk("lb_ok", {31'd0, mem_misaligned}, 32'd0);
    chk("lb_rd", {31'd0, mem_mem_read}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000); step();

    // Flush with both entries full and a bundle offered.
    mem_ready = 1'b0;
    drive(1'b1, 32'h44, 32'h0, 1'b0, 1'b0, 3'b000); step();
    drive(1'b1, 32'h55, 32'h0, 1'b0, 1'b0, 3'b000); step();
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 32'h0, 1'b0, 1'b0, 3'b000); step();
    flush = 1'b0;
    chk("flush_valid", {31'd0, mem_valid}, 32'd0);
    chk("flush_ready", {31'd0, ex_ready}, 32'd1);
    mem_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000); step();
    chk("flush_no_ghost", {31'd0, mem_valid}, 32'd0);

    // Reset mid-stream with both entries full.
    mem_ready = 1'b0;
    drive(1'b1, 32'h66, 32'h0, 1'b0, 1'b0, 3'b000); step();
    drive(1'b1, 32'h77, 32'h0, 1'b0, 1'b0, 3'b000); step();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_mid_alu", mem_alu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    drive(1'b1, 32'h88, 32'h0, 1'b0, 1'b0, 3'b000); step();
    chk("rst_first", mem_alu_result, 32'h88);
    chk("rst_first_valid", {31'd0, mem_valid}, 32'd1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      ex_valid      = ($urandom_range(0, 9) < 7);
      mem_ready     = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 99) < 3);
      ex_alu_result = $urandom;
      ex_rs2_data   = $urandom;
      ex_rd         = 5'($urandom_range(0, 31));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      ex_mem_write  = ex_mem_read ? 1'b0 : 1'($urandom_range(0, 1));
      ex_funct3     = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
